// File: rtl/ro_pair_counter.sv
// ro_pair_counter
// Measurement front-end of the RO-PUF datapath. Counts rising edges of two
// asynchronous ring-oscillator outputs over an identical gate window of
// WINDOW clk cycles and presents both 16-bit counts to the comparator.
// Owns the start/done handshake for one PUF bit evaluation.
//
// Optional feature macro: RO_SAT_EN
//   defined   : internal counters saturate at 16'hFFFF, port sat present
//   undefined : internal counters wrap modulo 2^16, no sat port
//
// count_1/count_2 are declared [0:15] (index 0 = MSB) to match the
// comparator; the numeric value is identical to a [15:0] vector.

module ro_pair_counter #(
    parameter int WINDOW      = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ro_a,
    input  logic        ro_b,
    output logic        busy,
    output logic        done,
    output logic [0:15] count_1,
    output logic [0:15] count_2
`ifdef RO_SAT_EN
    ,
    output logic        sat
`endif
);

    // Settle counter spans 0..SYNC_STAGES, window counter spans 0..WINDOW-1.
    localparam int SW = $clog2(SYNC_STAGES + 1);
    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SYNC_STAGES);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
    localparam logic [WW-1:0] WIN_LAST    = WW'(WINDOW - 1);
    localparam logic [WW-1:0] WIN_ONE     = WW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_COUNT  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic                   prev_a;
    logic                   prev_b;
    logic                   rise_a;
    logic                   rise_b;
    logic [15:0]            cnt_a;
    logic [15:0]            cnt_b;
    logic [15:0]            next_a;
    logic [15:0]            next_b;
    logic [SW-1:0]          settle_cnt;
    logic [WW-1:0]          win_cnt;

    // Advance an edge counter by one detected edge; saturating or wrapping
    // depending on the build.
    function automatic logic [15:0] bump(input logic [15:0] cnt, input logic hit);
        logic [15:0] res;
        res = cnt;
        if (hit) begin
`ifdef RO_SAT_EN
            if (cnt != 16'hFFFF) begin
                res = cnt + 16'd1;
            end else begin
                res = cnt;
            end
`else
            res = cnt + 16'd1;
`endif
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Synchronize both oscillators and keep the edge-detector history; runs in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
            prev_a <= 1'b0;
            prev_b <= 1'b0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], ro_a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], ro_b};
            prev_a <= sync_a[SYNC_STAGES-1];
            prev_b <= sync_b[SYNC_STAGES-1];
        end
    end

    // Rising-edge detect and next counter values for the current cycle.
    always_comb begin
        rise_a = sync_a[SYNC_STAGES-1] & ~prev_a;
        rise_b = sync_b[SYNC_STAGES-1] & ~prev_b;
        next_a = bump(cnt_a, rise_a);
        next_b = bump(cnt_b, rise_b);
    end

    // Measurement FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            cnt_a      <= 16'd0;
            cnt_b      <= 16'd0;
            settle_cnt <= '0;
            win_cnt    <= '0;
            count_1    <= 16'd0;
            count_2    <= 16'd0;
`ifdef RO_SAT_EN
            sat        <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= S_SETTLE;
                        busy       <= 1'b1;
                        settle_cnt <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SETTLE: begin
                    // Wait out the synchronizer + detector latency so only
                    // edges entering after start are counted.
                    cnt_a   <= 16'd0;
                    cnt_b   <= 16'd0;
                    win_cnt <= '0;
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= S_COUNT;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_ONE;
                    end
                end
                S_COUNT: begin
                    cnt_a <= next_a;
                    cnt_b <= next_b;
                    if (win_cnt == WIN_LAST) begin
                        // Results include the last window cycle's edges and
                        // become visible together with done.
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        count_1 <= next_a;
                        count_2 <= next_b;
`ifdef RO_SAT_EN
                        sat     <= (next_a == 16'hFFFF) | (next_b == 16'hFFFF);
`endif
                    end else begin
                        win_cnt <= win_cnt + WIN_ONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ro_pair_counter.sv
// Directed testbench for ro_pair_counter (WINDOW=16, SYNC_STAGES=2) plus a
// second instance with WINDOW=140000 for the 16-bit overflow behaviour.
// Build with or without RO_SAT_EN.

module tb_ro_pair_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start_big;
    logic        ro_a;
    logic        ro_b;
    logic        ro_fast;
    logic        busy;
    logic        done;
    logic [15:0] count_1;
    logic [15:0] count_2;
    logic        busy_big;
    logic        done_big;
    logic [15:0] count_1_big;
    logic [15:0] count_2_big;
    logic        zero_in;
`ifdef RO_SAT_EN
    logic        sat;
    logic        sat_big;
`endif

    int vecs;
    int errs;
    int per_a;
    int per_b;
    int ph;

    always #5 clk = ~clk;

    ro_pair_counter #(.WINDOW(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
        .busy(busy), .done(done), .count_1(count_1), .count_2(count_2)
`ifdef RO_SAT_EN
        , .sat(sat)
`endif
    );

    ro_pair_counter #(.WINDOW(140000), .SYNC_STAGES(2)) dut_big (
        .clk(clk), .rst(rst), .start(start_big), .ro_a(ro_fast), .ro_b(zero_in),
        .busy(busy_big), .done(done_big), .count_1(count_1_big), .count_2(count_2_big)
`ifdef RO_SAT_EN
        , .sat(sat_big)
`endif
    );

    // Oscillator models: change on the falling clk edge, periods in clk cycles.
    initial begin
        ph      = 0;
        ro_a    = 1'b0;
        ro_b    = 1'b0;
        ro_fast = 1'b0;
        zero_in = 1'b0;
        forever begin
            @(negedge clk);
            ph = ph + 1;
            if (per_a != 0) ro_a = ((ph % per_a) < (per_a / 2)); else ro_a = 1'b0;
            if (per_b != 0) ro_b = ((ph % per_b) < (per_b / 2)); else ro_b = 1'b0;
            ro_fast = ~ro_fast;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        start_big = 1'b0;
        repeat (3) @(negedge clk);
        vecs++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errs++; $display("FAIL reset_ctrl: busy=%b done=%b expected 0 0", busy, done);
        end
        vecs++;
        if (count_1 !== 16'd0 || count_2 !== 16'd0) begin
            errs++; $display("FAIL reset_counts: got %0d %0d expected 0 0", count_1, count_2);
        end
        vecs++;
        if (busy_big !== 1'b0 || count_1_big !== 16'd0) begin
            errs++; $display("FAIL reset_big: busy=%b count_1=%0d expected 0 0", busy_big, count_1_big);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int ndone;
        per_a = 4;
        per_b = 0;
        ndone = 0;
        repeat (8) @(negedge clk);
        vecs++;
        if (busy !== 1'b0) begin
            errs++; $display("FAIL basic_idle_busy: got %b expected 0", busy);
        end
        start = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done === 1'b1) ndone++;
            if (k == 1) begin
                vecs++;
                if (busy !== 1'b1) begin
                    errs++; $display("FAIL basic_busy_rise: got %b expected 1", busy);
                end
            end
            if (k == 19) begin
                vecs++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errs++; $display("FAIL basic_pre_done: busy=%b done=%b expected 1 0", busy, done);
                end
            end
            if (k == 20) begin
                vecs++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    errs++; $display("FAIL basic_done: done=%b busy=%b expected 1 0", done, busy);
                end
                vecs++;
                if (count_1 !== 16'd4 || count_2 !== 16'd0) begin
                    errs++; $display("FAIL basic_counts: got %0d %0d expected 4 0", count_1, count_2);
                end
            end
            if (k == 21) begin
                vecs++;
                if (done !== 1'b0) begin
                    errs++; $display("FAIL basic_done_width: got %b expected 0", done);
                end
            end
        end
        vecs++;
        if (ndone != 1) begin
            errs++; $display("FAIL basic_done_count: got %0d expected 1", ndone);
        end
    endtask

    task automatic test_ratio_hold();
        int k;
        int bad;
        per_a = 8;
        per_b = 4;
        repeat (16) @(negedge clk);
        start = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            start = 1'b0;
        end while (done !== 1'b1 && k < 40);
        vecs++;
        if (k != 20) begin
            errs++; $display("FAIL ratio_done_cycle: got %0d expected 20", k);
        end
        vecs++;
        if (count_1 !== 16'd2 || count_2 !== 16'd4) begin
            errs++; $display("FAIL ratio_counts: got %0d %0d expected 2 4", count_1, count_2);
        end
        vecs++;
        if (!(count_2 > count_1)) begin
            errs++; $display("FAIL ratio_order: count_2=%0d not above count_1=%0d", count_2, count_1);
        end
        bad = 0;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            vecs++;
            if (count_1 !== 16'd2 || count_2 !== 16'd4) begin
                errs++; bad++;
                if (bad < 4) $display("FAIL ratio_hold: cycle %0d got %0d %0d expected 2 4", j, count_1, count_2);
            end
        end
    endtask

    task automatic test_abort();
        int ndone;
        ndone = 0;
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        vecs++;
        if (busy !== 1'b1) begin
            errs++; $display("FAIL abort_busy_before: got %b expected 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vecs++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errs++; $display("FAIL abort_ctrl: busy=%b done=%b expected 0 0", busy, done);
        end
        vecs++;
        if (count_1 !== 16'd0 || count_2 !== 16'd0) begin
            errs++; $display("FAIL abort_counts: got %0d %0d expected 0 0", count_1, count_2);
        end
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        vecs++;
        if (ndone != 0) begin
            errs++; $display("FAIL abort_no_done: got %0d pulses expected 0", ndone);
        end
    endtask

    task automatic test_ignore_start();
        int ndone;
        int at;
        ndone = 0;
        at = -1;
        start = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            start = (k == 2) || (k == 8) || (k == 20);
            if (done === 1'b1) begin
                ndone++;
                at = k;
            end
            if (k == 22) begin
                vecs++;
                if (busy !== 1'b0) begin
                    errs++; $display("FAIL ignore_done_start: busy=%b expected 0", busy);
                end
            end
        end
        start = 1'b0;
        vecs++;
        if (ndone != 1 || at != 20) begin
            errs++; $display("FAIL ignore_single_done: got %0d pulses last at %0d expected 1 at 20", ndone, at);
        end
        vecs++;
        if (count_1 !== 16'd2 || count_2 !== 16'd4) begin
            errs++; $display("FAIL ignore_counts: got %0d %0d expected 2 4", count_1, count_2);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        int   bad;
        bad = 0;
        start = 1'b1;
        for (int k = 1; k <= 90; k++) begin
            @(negedge clk);
            if (k == 64) start = 1'b0;
            exp_done = (k == 20) || (k == 41) || (k == 62) || (k == 83);
            vecs++;
            if (done !== exp_done) begin
                errs++; bad++;
                if (bad < 6) $display("FAIL b2b_done: cycle %0d got %b expected %b", k, done, exp_done);
            end
            if (exp_done) begin
                vecs++;
                if (count_1 !== 16'd2 || count_2 !== 16'd4) begin
                    errs++; $display("FAIL b2b_counts: cycle %0d got %0d %0d expected 2 4", k, count_1, count_2);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int k;
        start_big = 1'b1;
        @(negedge clk);
        start_big = 1'b0;
        k = 1;
        while (done_big !== 1'b1 && k < 140100) begin
            @(negedge clk);
            k++;
        end
        vecs++;
        if (k != 140004) begin
            errs++; $display("FAIL wrap_done_cycle: got %0d expected 140004", k);
        end
`ifdef RO_SAT_EN
        vecs++;
        if (count_1_big !== 16'hFFFF || sat_big !== 1'b1) begin
            errs++; $display("FAIL sat_count: got %h sat=%b expected ffff 1", count_1_big, sat_big);
        end
        vecs++;
        if (sat !== 1'b0) begin
            errs++; $display("FAIL sat_small: got %b expected 0", sat);
        end
`else
        vecs++;
        if (count_1_big !== 16'd4464) begin
            errs++; $display("FAIL wrap_count: got %0d expected 4464", count_1_big);
        end
`endif
        vecs++;
        if (count_2_big !== 16'd0) begin
            errs++; $display("FAIL wrap_count_2: got %0d expected 0", count_2_big);
        end
    endtask

    initial begin
        vecs  = 0;
        errs  = 0;
        per_a = 0;
        per_b = 0;
        rst   = 1'b1;
        start = 1'b0;
        start_big = 1'b0;
        test_reset();
        test_basic();
        test_ratio_hold();
        test_abort();
        per_a = 8;
        per_b = 4;
        repeat (8) @(negedge clk);
        test_ignore_start();
        repeat (4) @(negedge clk);
        test_back_to_back();
        repeat (4) @(negedge clk);
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/ro_pair_counter.md
# ro_pair_counter

Measurement front-end of the RO-PUF datapath. Counts rising edges of two ring-oscillator outputs over an identical, fixed gate window and presents the two 16-bit counts to the downstream comparator, which turns them into one response bit. The block owns the start/done handshake for one PUF bit evaluation. Oscillator enable and challenge muxing live upstream.

## Interface
- WINDOW, 1024: gate length in clk cycles; ≥1, ≤2^20.
- SYNC_STAGES, 2: flip-flop synchronizer depth per oscillator input; ≥2.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one measurement; sampled only in IDLE.
- ro_a  in  1  oscillator A output, asynchronous to clk.
- ro_b  in  1  oscillator B output, asynchronous to clk.
- busy  out  1  high while SETTLE or COUNT.
- done  out  1  one-cycle pulse; counts valid from this cycle.
- count_1  out  16  edge count of ro_a, declared [0:15] (index 0 = MSB) to match comparator.
- count_2  out  16  edge count of ro_b, same declaration.
- sat  out  1  present only with RO_SAT_EN (see Configuration).

## Operation
- Each ro input passes through SYNC_STAGES flops, then a 1-flop edge detector; edge = sync & ~prev. The prev register updates every cycle in every state.
- FSM states:
  - IDLE: start=1 → SETTLE; else stay.
  - SETTLE: internal counters cleared; lasts SYNC_STAGES+1 cycles → COUNT.
  - COUNT: each detected edge increments its internal counter; window counter runs WINDOW cycles → DONE.
  - DONE: one cycle; internal counters copied to count_1/count_2, done=1 → IDLE.
- count_1/count_2 are registered and hold their value until the next DONE.
- start outside IDLE is ignored; no queuing.
- Internal counters are 16 bits. Behaviour at 16'hFFFF+1 is set by RO_SAT_EN.
- Oscillator frequency must be < clk/2 for exact counts; faster inputs undercount. This is not detected.
- rst in any state: next cycle state=IDLE; busy, done, count_1, count_2, sat, internal and window counters = 0; synchronizers = 0. An aborted measurement produces no done.

## Timing
- start=1 in IDLE cycle T.
- SETTLE occupies T+1 … T+SYNC_STAGES+1; busy rises at T+1.
- COUNT occupies the next WINDOW cycles.
- DONE at T+SYNC_STAGES+WINDOW+2: done=1, busy=0, new counts visible.
- IDLE at DONE+1. Earliest next start is sampled at DONE+1.
- Continuous start=1 gives one measurement every SYNC_STAGES+WINDOW+3 cycles.
- Edges are counted only if they reach the edge detector during a COUNT cycle. Input-to-detect latency is SYNC_STAGES+1 cycles, which the SETTLE length covers.

## Configuration
- RO_SAT_EN defined:
  - Counters saturate at 16'hFFFF.
  - Port sat = OR of both counters' saturation, latched in DONE and held with the counts; cleared by rst.
- RO_SAT_EN undefined:
  - Counters wrap modulo 2^16.
  - Port sat and its logic are absent.

## Test plan
- WINDOW=16, SYNC_STAGES=2; ro_a period 4 clk, ro_b held 0; start pulse at T → busy at T+1, done at T+20 for exactly 1 cycle, count_1=4, count_2=0.
- Same config; ro_a period 8, ro_b period 4 → count_1=2, count_2=4. Comparator consumer sees count_2 > count_1; counts stay unchanged for 50 cycles after done.
- WINDOW=140000; ro_a toggled every clk, phase-aligned (70000 edges):
  - RO_SAT_EN defined → count_1=16'hFFFF, sat=1.
  - RO_SAT_EN undefined → count_1=4464.
- rst asserted mid-COUNT (cycle T+10) → next cycle busy=0, count_1=count_2=0; no done pulse within 100 cycles.
- start re-pulsed during SETTLE and COUNT → ignored; exactly one done at T+20.
- start held high continuously → done pulses every 21 cycles with consistent counts.
